// File: rtl/tlb_lookup_resolve_if.sv
// Bundle of TLB array snapshot, two lookup request ports, two result ports,
// flush and the per-port performance counters.
interface tlb_lookup_resolve_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  logic [TLBNUM*20-1:0] all_pfn0;
  logic [TLBNUM*20-1:0] all_pfn1;
  logic [TLBNUM*3-1:0]  all_c0;
  logic [TLBNUM*3-1:0]  all_c1;
  logic [TLBNUM-1:0]    all_d0;
  logic [TLBNUM-1:0]    all_d1;
  logic [TLBNUM-1:0]    all_v0;
  logic [TLBNUM-1:0]    all_v1;

  logic                 s0_valid;
  logic                 s0_ready;
  logic [TLBNUM-1:0]    s0_found;
  logic                 s0_odd;
  logic                 s0_store;
  logic                 s1_valid;
  logic                 s1_ready;
  logic [TLBNUM-1:0]    s1_found;
  logic                 s1_odd;
  logic                 s1_store;

  logic                 r0_valid;
  logic                 r0_ready;
  logic                 r0_hit;
  logic [IDXW-1:0]      r0_index;
  logic [19:0]          r0_pfn;
  logic [2:0]           r0_c;
  logic [1:0]           r0_exc;
  logic                 r0_multi;
  logic                 r1_valid;
  logic                 r1_ready;
  logic                 r1_hit;
  logic [IDXW-1:0]      r1_index;
  logic [19:0]          r1_pfn;
  logic [2:0]           r1_c;
  logic [1:0]           r1_exc;
  logic                 r1_multi;

  logic                 flush;
  logic [31:0]          cnt0_hit;
  logic [31:0]          cnt0_miss;
  logic [31:0]          cnt1_hit;
  logic [31:0]          cnt1_miss;

  modport master (
    output all_pfn0, all_pfn1, all_c0, all_c1, all_d0, all_d1, all_v0, all_v1,
    output s0_valid, s0_found, s0_odd, s0_store,
    output s1_valid, s1_found, s1_odd, s1_store,
    output r0_ready, r1_ready, flush,
    input  s0_ready, s1_ready,
    input  r0_valid, r0_hit, r0_index, r0_pfn, r0_c, r0_exc, r0_multi,
    input  r1_valid, r1_hit, r1_index, r1_pfn, r1_c, r1_exc, r1_multi,
    input  cnt0_hit, cnt0_miss, cnt1_hit, cnt1_miss
  );

  modport slave (
    input  all_pfn0, all_pfn1, all_c0, all_c1, all_d0, all_d1, all_v0, all_v1,
    input  s0_valid, s0_found, s0_odd, s0_store,
    input  s1_valid, s1_found, s1_odd, s1_store,
    input  r0_ready, r1_ready, flush,
    output s0_ready, s1_ready,
    output r0_valid, r0_hit, r0_index, r0_pfn, r0_c, r0_exc, r0_multi,
    output r1_valid, r1_hit, r1_index, r1_pfn, r1_c, r1_exc, r1_multi,
    output cnt0_hit, cnt0_miss, cnt1_hit, cnt1_miss
  );
endinterface

// File: rtl/tlb_lookup_resolve.sv
// Resolves TLB compare-stage match vectors into PFN/attribute/exception results
// for two independent lookup ports, each behind a single-entry result register.
module tlb_lookup_resolve #(
  parameter int TLBNUM = 16
) (
  input logic                 clk,
  input logic                 rstn,
  tlb_lookup_resolve_if.slave bus
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] index;
    logic [19:0]     pfn;
    logic [2:0]      c;
    logic [1:0]      exc;
    logic            multi;
  } res_t;

  logic [TLBNUM*20-1:0] pfn0_a, pfn1_a;
  logic [TLBNUM*3-1:0]  c0_a, c1_a;
  logic [TLBNUM-1:0]    d0_a, d1_a, v0_a, v1_a;

  assign pfn0_a = bus.all_pfn0;
  assign pfn1_a = bus.all_pfn1;
  assign c0_a   = bus.all_c0;
  assign c1_a   = bus.all_c1;
  assign d0_a   = bus.all_d0;
  assign d1_a   = bus.all_d1;
  assign v0_a   = bus.all_v0;
  assign v1_a   = bus.all_v1;

  // Priority pick of the lowest matching entry, then page select and exception.
  function automatic res_t resolve(input logic [TLBNUM-1:0] found,
                                   input logic odd, input logic store);
    res_t          r;
    logic [IDXW:0] ones;
    logic          v;
    logic          d;
    r    = '0;
    ones = '0;
    v    = 1'b0;
    d    = 1'b0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (found[i]) r.index = IDXW'(i);
    end
    for (int i = 0; i < TLBNUM; i++) begin
      ones = ones + (IDXW+1)'(found[i]);
    end
    r.hit   = |found;
    r.multi = (ones > (IDXW+1)'(1));
    if (r.hit) begin
      r.pfn = odd ? pfn1_a[20*r.index +: 20] : pfn0_a[20*r.index +: 20];
      r.c   = odd ? c1_a[3*r.index +: 3]     : c0_a[3*r.index +: 3];
      v     = odd ? v1_a[r.index]            : v0_a[r.index];
      d     = odd ? d1_a[r.index]            : d0_a[r.index];
    end
    if (!r.hit)             r.exc = 2'd1;
    else if (!v)            r.exc = 2'd2;
    else if (store && !d)   r.exc = 2'd3;
    else                    r.exc = 2'd0;
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 32'd1;
  endfunction

  res_t        res0_p0, res1_p0;
  res_t        res0_p1, res1_p1;
  logic        vld0_p1, vld1_p1;
  logic        rdy0_p0, rdy1_p0;
  logic        acc0_p0, acc1_p0;
  logic [31:0] cnt0_hit_p1, cnt0_miss_p1, cnt1_hit_p1, cnt1_miss_p1;

  // Stage p0: combinational resolve of the presented request.
  always_comb res0_p0 = resolve(bus.s0_found, bus.s0_odd, bus.s0_store);
  always_comb res1_p0 = resolve(bus.s1_found, bus.s1_odd, bus.s1_store);

  assign rdy0_p0 = rstn && !bus.flush && (!vld0_p1 || bus.r0_ready);
  assign rdy1_p0 = rstn && !bus.flush && (!vld1_p1 || bus.r1_ready);
  assign acc0_p0 = bus.s0_valid && rdy0_p0;
  assign acc1_p0 = bus.s1_valid && rdy1_p0;

  // Stage p1: result registers, held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld0_p1 <= 1'b0;
      res0_p1 <= '0;
    end else if (bus.flush) begin
      vld0_p1 <= 1'b0;
    end else if (acc0_p0) begin
      vld0_p1 <= 1'b1;
      res0_p1 <= res0_p0;
    end else if (bus.r0_ready) begin
      vld0_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld1_p1 <= 1'b0;
      res1_p1 <= '0;
    end else if (bus.flush) begin
      vld1_p1 <= 1'b0;
    end else if (acc1_p0) begin
      vld1_p1 <= 1'b1;
      res1_p1 <= res1_p0;
    end else if (bus.r1_ready) begin
      vld1_p1 <= 1'b0;
    end
  end

  // Accepts are already blocked during flush, so counters only see flush=0 traffic.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt0_hit_p1  <= '0;
      cnt0_miss_p1 <= '0;
      cnt1_hit_p1  <= '0;
      cnt1_miss_p1 <= '0;
    end else begin
      if (acc0_p0 &&  res0_p0.hit) cnt0_hit_p1  <= sat_inc(cnt0_hit_p1);
      if (acc0_p0 && !res0_p0.hit) cnt0_miss_p1 <= sat_inc(cnt0_miss_p1);
      if (acc1_p0 &&  res1_p0.hit) cnt1_hit_p1  <= sat_inc(cnt1_hit_p1);
      if (acc1_p0 && !res1_p0.hit) cnt1_miss_p1 <= sat_inc(cnt1_miss_p1);
    end
  end

  assign bus.s0_ready  = rdy0_p0;
  assign bus.s1_ready  = rdy1_p0;
  assign bus.r0_valid  = vld0_p1;
  assign bus.r0_hit    = res0_p1.hit;
  assign bus.r0_index  = res0_p1.index;
  assign bus.r0_pfn    = res0_p1.pfn;
  assign bus.r0_c      = res0_p1.c;
  assign bus.r0_exc    = res0_p1.exc;
  assign bus.r0_multi  = res0_p1.multi;
  assign bus.r1_valid  = vld1_p1;
  assign bus.r1_hit    = res1_p1.hit;
  assign bus.r1_index  = res1_p1.index;
  assign bus.r1_pfn    = res1_p1.pfn;
  assign bus.r1_c      = res1_p1.c;
  assign bus.r1_exc    = res1_p1.exc;
  assign bus.r1_multi  = res1_p1.multi;
  assign bus.cnt0_hit  = cnt0_hit_p1;
  assign bus.cnt0_miss = cnt0_miss_p1;
  assign bus.cnt1_hit  = cnt1_hit_p1;
  assign bus.cnt1_miss = cnt1_miss_p1;
endmodule

// File: tb/tb_tlb_lookup_resolve.sv
// Bench for tlb_lookup_resolve: directed scenarios plus random traffic checked
// against a per-entry array model of the TLB and a transaction-level result model.
module tb_tlb_lookup_resolve;
  localparam int N = 16;
  localparam logic [31:0] MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        hit;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic [1:0]  exc;
    logic        multi;
  } mres_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  tlb_lookup_resolve_if #(.TLBNUM(N)) bus ();
  tlb_lookup_resolve #(.TLBNUM(N)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  logic [19:0] tpfn0 [N];
  logic [19:0] tpfn1 [N];
  logic [2:0]  tc0 [N];
  logic [2:0]  tc1 [N];
  logic        td0 [N];
  logic        td1 [N];
  logic        tv0 [N];
  logic        tv1 [N];

  logic        sv [2];
  logic [15:0] sfound [2];
  logic        sodd [2];
  logic        sstore [2];
  logic        rr [2];
  logic        flush;

  logic        ords [2];
  logic        ov [2];
  mres_t       ores [2];
  logic [31:0] och [2];
  logic [31:0] ocm [2];

  logic        mv [2];
  mres_t       mres [2];
  logic [31:0] mch [2];
  logic [31:0] mcm [2];

  int n_assert = 0;
  int n_fail = 0;

  always_comb begin
    bus.all_pfn0 = '0;
    bus.all_pfn1 = '0;
    bus.all_c0   = '0;
    bus.all_c1   = '0;
    bus.all_d0   = '0;
    bus.all_d1   = '0;
    bus.all_v0   = '0;
    bus.all_v1   = '0;
    for (int i = 0; i < N; i++) begin
      bus.all_pfn0[20*i +: 20] = tpfn0[i];
      bus.all_pfn1[20*i +: 20] = tpfn1[i];
      bus.all_c0[3*i +: 3]     = tc0[i];
      bus.all_c1[3*i +: 3]     = tc1[i];
      bus.all_d0[i]            = td0[i];
      bus.all_d1[i]            = td1[i];
      bus.all_v0[i]            = tv0[i];
      bus.all_v1[i]            = tv1[i];
    end
  end

  always_comb begin
    bus.s0_valid = sv[0];     bus.s1_valid = sv[1];
    bus.s0_found = sfound[0]; bus.s1_found = sfound[1];
    bus.s0_odd   = sodd[0];   bus.s1_odd   = sodd[1];
    bus.s0_store = sstore[0]; bus.s1_store = sstore[1];
    bus.r0_ready = rr[0];     bus.r1_ready = rr[1];
    bus.flush    = flush;
  end

  always_comb begin
    ords[0] = bus.s0_ready;
    ords[1] = bus.s1_ready;
    ov[0]   = bus.r0_valid;
    ov[1]   = bus.r1_valid;
    ores[0] = {bus.r0_hit, bus.r0_index, bus.r0_pfn, bus.r0_c, bus.r0_exc, bus.r0_multi};
    ores[1] = {bus.r1_hit, bus.r1_index, bus.r1_pfn, bus.r1_c, bus.r1_exc, bus.r1_multi};
    och[0]  = bus.cnt0_hit;
    och[1]  = bus.cnt1_hit;
    ocm[0]  = bus.cnt0_miss;
    ocm[1]  = bus.cnt1_miss;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference translation: lowest matching entry, chosen page, exception priority.
  function automatic mres_t ref_res(input int p);
    mres_t r;
    int    idx;
    logic  v;
    logic  d;
    r = '0;
    r.exc = 2'd1;
    if (sfound[p] != 16'h0) begin
      idx = 0;
      while (!sfound[p][idx]) idx++;
      r.hit   = 1'b1;
      r.index = 4'(idx);
      r.multi = ($countones(sfound[p]) >= 2);
      r.pfn   = sodd[p] ? tpfn1[idx] : tpfn0[idx];
      r.c     = sodd[p] ? tc1[idx] : tc0[idx];
      v       = sodd[p] ? tv1[idx] : tv0[idx];
      d       = sodd[p] ? td1[idx] : td0[idx];
      r.exc   = !v ? 2'd2 : ((sstore[p] && !d) ? 2'd3 : 2'd0);
    end
    return r;
  endfunction

  task automatic step();
    logic mrdy;
    #1;
    for (int p = 0; p < 2; p++) begin
      mrdy = rstn && !flush && (!mv[p] || rr[p]);
      check($sformatf("s%0d_ready", p), 64'(ords[p]), 64'(mrdy));
      if (!rstn) begin
        mv[p] = 1'b0; mres[p] = '0; mch[p] = '0; mcm[p] = '0;
      end else if (flush) begin
        mv[p] = 1'b0;
      end else if (sv[p] && mrdy) begin
        mres[p] = ref_res(p);
        mv[p] = 1'b1;
        if (mres[p].hit) begin
          if (mch[p] != MAX) mch[p] = mch[p] + 32'd1;
        end else begin
          if (mcm[p] != MAX) mcm[p] = mcm[p] + 32'd1;
        end
      end else if (rr[p]) begin
        mv[p] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("r%0d_valid", p), 64'(ov[p]), 64'(mv[p]));
      check($sformatf("r%0d_result", p), 64'(ores[p]), 64'(mres[p]));
      check($sformatf("cnt%0d_hit", p), 64'(och[p]), 64'(mch[p]));
      check($sformatf("cnt%0d_miss", p), 64'(ocm[p]), 64'(mcm[p]));
    end
  endtask

  logic [31:0] save_h [2];
  logic [31:0] save_m [2];
  int          k;

  initial begin
    for (int i = 0; i < N; i++) begin
      tpfn0[i] = 20'($urandom); tpfn1[i] = 20'($urandom);
      tc0[i] = 3'($urandom);    tc1[i] = 3'($urandom);
      td0[i] = 1'($urandom);    td1[i] = 1'($urandom);
      tv0[i] = 1'($urandom);    tv1[i] = 1'($urandom);
    end
    for (int p = 0; p < 2; p++) begin
      sv[p] = 1'b1; sfound[p] = 16'h0001; sodd[p] = 1'b0; sstore[p] = 1'b0; rr[p] = 1'b1;
      mv[p] = 1'b0; mres[p] = '0; mch[p] = '0; mcm[p] = '0;
    end
    flush = 1'b0;
    rstn  = 1'b0;

    // Reset with requests pending: dropped, outputs cleared.
    step();
    step();
    check("reset_r0_valid", 64'(ov[0]), 64'd0);
    check("reset_r0_pfn", 64'(ores[0].pfn), 64'd0);
    rstn = 1'b1;
    sv[1] = 1'b0;

    // Odd-page hit on entry 5.
    tpfn1[5] = 20'hABCDE; tv1[5] = 1'b1; td1[5] = 1'b1;
    sfound[0] = 16'h0020; sodd[0] = 1'b1;
    step();
    check("hit_valid", 64'(ov[0]), 64'd1);
    check("hit_hit", 64'(ores[0].hit), 64'd1);
    check("hit_index", 64'(ores[0].index), 64'd5);
    check("hit_pfn", 64'(ores[0].pfn), 64'hABCDE);
    check("hit_exc", 64'(ores[0].exc), 64'd0);

    // Miss on port 0, multi-hit on port 1.
    sfound[0] = 16'h0000;
    sv[1] = 1'b1; sfound[1] = 16'h0104;
    step();
    check("miss_exc", 64'(ores[0].exc), 64'd1);
    check("miss_hit", 64'(ores[0].hit), 64'd0);
    check("multi_index", 64'(ores[1].index), 64'd2);
    check("multi_flag", 64'(ores[1].multi), 64'd1);
    sv[1] = 1'b0;

    // Invalid even page, then store to clean page.
    tv0[3] = 1'b0; sfound[0] = 16'h0008; sodd[0] = 1'b0;
    step();
    check("inval_exc", 64'(ores[0].exc), 64'd2);
    tv0[3] = 1'b1; td0[3] = 1'b0; sstore[0] = 1'b1;
    step();
    check("modify_exc", 64'(ores[0].exc), 64'd3);

    // Backpressure: result held, arrays changed underneath, no accept.
    rr[0] = 1'b0; sstore[0] = 1'b0; sfound[0] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      tpfn0[3] = 20'($urandom); td0[3] = 1'b1;
      step();
      check("bp_ready", 64'(ords[0]), 64'd0);
      check("bp_exc_held", 64'(ores[0].exc), 64'd3);
    end
    rr[0] = 1'b1;
    step();
    check("b2b_first_index", 64'(ores[0].index), 64'd0);
    sfound[0] = 16'h0040;
    step();
    check("b2b_second_valid", 64'(ov[0]), 64'd1);
    check("b2b_second_index", 64'(ores[0].index), 64'd6);

    // Flush with both results held.
    rr[0] = 1'b0; rr[1] = 1'b0; sv[1] = 1'b1; sfound[1] = 16'h0000;
    step();
    step();
    save_h[0] = och[0]; save_m[0] = ocm[0]; save_h[1] = och[1]; save_m[1] = ocm[1];
    flush = 1'b1;
    #1;
    check("flush_s0_ready", 64'(ords[0]), 64'd0);
    check("flush_s1_ready", 64'(ords[1]), 64'd0);
    step();
    check("flush_r0_valid", 64'(ov[0]), 64'd0);
    check("flush_r1_valid", 64'(ov[1]), 64'd0);
    check("flush_cnt0_hit", 64'(och[0]), 64'(save_h[0]));
    check("flush_cnt1_miss", 64'(ocm[1]), 64'(save_m[1]));
    flush = 1'b0;

    // Reset mid-operation with held results.
    step();
    rstn = 1'b0;
    step();
    check("midreset_r1_valid", 64'(ov[1]), 64'd0);
    rstn = 1'b1;
    rr[0] = 1'b1; rr[1] = 1'b1;

    // Random traffic.
    for (int t = 0; t < 600; t++) begin
      for (int p = 0; p < 2; p++) begin
        sv[p] = ($urandom_range(3) != 0);
        rr[p] = ($urandom_range(2) != 0);
        sodd[p] = 1'($urandom);
        sstore[p] = 1'($urandom);
        case ($urandom_range(2))
          0: sfound[p] = 16'h0000;
          1: sfound[p] = 16'h0001 << $urandom_range(15);
          default: sfound[p] = 16'($urandom);
        endcase
      end
      flush = ($urandom_range(19) == 0);
      k = $urandom_range(N - 1);
      tpfn0[k] = 20'($urandom); tpfn1[k] = 20'($urandom);
      tc0[k] = 3'($urandom);    tc1[k] = 3'($urandom);
      td0[k] = 1'($urandom);    td1[k] = 1'($urandom);
      tv0[k] = 1'($urandom);    tv1[k] = 1'($urandom);
      step();
    end
    flush = 1'b0;

    // Hit-counter saturation from a preloaded near-max value.
    sv[0] = 1'b1; rr[0] = 1'b1; sfound[0] = 16'h0010; sv[1] = 1'b0;
    force dut.cnt0_hit_p1 = 32'hFFFF_FFFE;
    #1;
    release dut.cnt0_hit_p1;
    mch[0] = 32'hFFFF_FFFE;
    check("sat_preload", 64'(och[0]), 64'hFFFF_FFFE);
    step();
    check("sat_first", 64'(och[0]), 64'hFFFF_FFFF);
    step();
    check("sat_held", 64'(och[0]), 64'hFFFF_FFFF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tlb_lookup_resolve.md
TLB_LOOKUP_RESOLVE -- requirements
Module: tlb_lookup_resolve

Interface
REQ-001 Parameter: TLBNUM, 16, number of TLB entries; IDXW = $clog2(TLBNUM).
REQ-002 Port list: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port list: rstn  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port list: all_pfn0, all_pfn1  in  TLBNUM*20  even/odd page frame numbers; entry i at [20*i+19:20*i].
REQ-005 Port list: all_c0, all_c1  in  TLBNUM*3  even/odd cache attributes; entry i at [3*i+2:3*i].
REQ-006 Port list: all_d0, all_d1, all_v0, all_v1  in  TLBNUM  even/odd dirty and valid bits.
REQ-007 Port list: sN_valid  in  1  lookup request on port N (N=0,1).
REQ-008 Port list: sN_ready  out  1  port N accepts a request this cycle.
REQ-009 Port list: sN_found  in  TLBNUM  per-entry match vector from the compare stage.
REQ-010 Port list: sN_odd  in  1  selects odd page (vaddr bit 12).
REQ-011 Port list: sN_store  in  1  request is a store.
REQ-012 Port list: rN_valid  out  1  registered result valid.
REQ-013 Port list: rN_ready  in  1  consumer takes the result.
REQ-014 Port list: rN_hit  out  1  at least one entry matched.
REQ-015 Port list: rN_index  out  IDXW  lowest matching entry index.
REQ-016 Port list: rN_pfn  out  20  selected PFN.
REQ-017 Port list: rN_c  out  3  selected cache attribute.
REQ-018 Port list: rN_exc  out  2  exception code: 0 none, 1 refill, 2 invalid, 3 modify.
REQ-019 Port list: rN_multi  out  1  more than one entry matched.
REQ-020 Port list: flush  in  1  discard all held results.
REQ-021 Port list: cntN_hit, cntN_miss  out  32  saturating performance counters for port N.

Function
REQ-022 Ports 0 and 1 SHALL be fully independent; no shared state except flush and reset.
REQ-023 sN_ready SHALL equal !rN_valid || rN_ready (single-entry pipeline register, no skid).
REQ-024 Accept on sN_valid && sN_ready: result registers load; rN_valid=1 next cycle (latency 1).
REQ-025 rN_valid && !rN_ready SHALL hold all rN_* outputs stable until the transfer.
REQ-026 rN_valid && rN_ready with no accept SHALL clear rN_valid next cycle.
REQ-027 Index SHALL be the lowest set bit of sN_found; rN_multi=1 when popcount(sN_found)>=2.
REQ-028 Page select: sN_odd=0 uses pfn0/c0/d0/v0 of the selected entry; sN_odd=1 uses pfn1/c1/d1/v1.
REQ-029 rN_exc priority: no hit -> 1; else v=0 -> 2; else sN_store && d=0 -> 3; else 0.
REQ-030 On miss (sN_found all zero): rN_hit=0, rN_index=0, rN_pfn=0, rN_c=0, rN_multi=0.
REQ-031 TLB arrays SHALL be sampled only in the accept cycle; later array changes do not alter held results.
REQ-032 flush=1 SHALL clear rN_valid next cycle for both ports and block accepts that cycle (sN_ready=0).
REQ-033 cntN_hit increments by 1 on each accepted request with a hit; cntN_miss on each accepted miss; both saturate at 32'hFFFF_FFFF.
REQ-034 Counters SHALL count accepts made during flush=0 only; flush does not clear counters.

Reset
REQ-035 rstn=0 at a clk edge SHALL set rN_valid=0, rN_hit=0, rN_index=0, rN_pfn=0, rN_c=0, rN_exc=0, rN_multi=0, cntN_hit=0, cntN_miss=0.
REQ-036 While rstn=0, sN_ready SHALL be 0; a request asserted during reset is dropped.
REQ-037 Reset mid-operation discards any held result without handshake.

Verification
REQ-038 Hit: s0_found=16'h0020, s0_odd=1, entry5 pfn1=20'hABCDE, v1=1, d1=1, load -> next cycle r0_valid=1, r0_hit=1, r0_index=5, r0_pfn=20'hABCDE, r0_exc=0.
REQ-039 Miss/exceptions: found=0 -> r0_exc=1, r0_hit=0; hit with v0=0 -> exc=2; store, v0=1, d0=0 -> exc=3.
REQ-040 Multi-hit: s1_found=16'h0104 -> r1_index=2, r1_multi=1.
REQ-041 Backpressure: r0_ready=0 for 3 cycles after a result -> s0_ready=0, outputs stable; r0_ready=1 with new request same cycle -> back-to-back results, no bubble.
REQ-042 Flush with both results held -> both rN_valid=0 next cycle, sN_ready=0 in flush cycle, counters unchanged.
REQ-043 Counter saturation: preload cnt0_hit to 32'hFFFF_FFFE via 2^32-2 accepted hits (or force), two more hits -> 32'hFFFF_FFFF held.
